encoder_velocity: RTL and testbench

- Downstream consumer of the quadrature encoder counter. Samples the signed 32-bit position count on a fixed clock-count window.
- Produces per-window velocity (count delta), a moving-average velocity and the latched position.
- Hands each sample to the controller/bus side with a valid/ack handshake and a sticky overrun flag.

---
 rtl/encoder_velocity.sv | 149 ++++++++++++++
 tb/tb_encoder_velocity.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_velocity.sv
// Windowed velocity estimator for a signed 32-bit encoder position count.
// Emits clamped per-window delta, a 2^AVG_LOG2 moving average and the latched position with a valid/ack handshake.
module encoder_velocity #(
    parameter int WINDOW   = 50000,
    parameter int VEL_W    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [31:0]      Count,
    output logic signed [VEL_W-1:0] Velocity,
    output logic signed [VEL_W-1:0] Velocity_avg,
    output logic signed [31:0]      Position_latched,
    output logic                    sample_valid,
    input  logic                    sample_ack,
    output logic                    saturated,
    output logic                    overrun
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = VEL_W + AVG_LOG2;
    localparam logic [CW-1:0]      LAST = CW'(WINDOW - 1);
    localparam logic signed [31:0] VMAX = $signed(32'h7FFF_FFFF >> (32 - VEL_W));
    localparam logic signed [31:0] VMIN = ~VMAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic signed [31:0]      prev_q;
    logic signed [VEL_W-1:0] hist_q [N];
    logic                    pending_q;
    logic signed [VEL_W-1:0] vel_q;
    logic signed [VEL_W-1:0] avg_q;
    logic signed [31:0]      pos_q;
    logic                    valid_q;
    logic                    sat_q;
    logic                    overrun_q;

    logic                    tick_d;
    logic signed [31:0]      delta_d;
    logic signed [31:0]      clamp_d;
    logic                    sat_d;
    logic signed [VEL_W-1:0] vel_d;
    logic signed [SW-1:0]    sum_d;
    logic signed [VEL_W-1:0] avg_d;

    // Sample datapath: modulo delta, clamp, and average including the incoming value.
    always_comb begin
        tick_d  = (cnt_q == LAST);
        delta_d = Count - prev_q;
        if (delta_d > VMAX) begin
            clamp_d = VMAX;
            sat_d   = 1'b1;
        end else if (delta_d < VMIN) begin
            clamp_d = VMIN;
            sat_d   = 1'b1;
        end else begin
            clamp_d = delta_d;
            sat_d   = 1'b0;
        end
        vel_d = VEL_W'(clamp_d);
        sum_d = SW'(vel_d);
        for (int i = 0; i < N - 1; i++) begin
            sum_d = sum_d + SW'(hist_q[i]);
        end
        avg_d = VEL_W'(sum_d >>> AVG_LOG2);
    end

    // Sequencer, window counter, history and handshake state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= '0;
            pending_q <= 1'b0;
            vel_q     <= '0;
            avg_q     <= '0;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            // An ack coinciding with a new pulse retires the older sample only.
            if (valid_q) begin
                pending_q <= 1'b1;
                if (pending_q && !sample_ack) overrun_q <= 1'b1;
            end else if (sample_ack) begin
                pending_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    pending_q <= 1'b0;
                    overrun_q <= 1'b0;
                    if (enable) begin
                        state_q <= PRIME;
                        for (int i = 0; i < N; i++) hist_q[i] <= '0;
                    end
                end
                PRIME, RUN: begin
                    if (!enable) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                        overrun_q <= 1'b0;
                        for (int i = 0; i < N; i++) hist_q[i] <= '0;
                    end else begin
                        cnt_q <= tick_d ? '0 : cnt_q + CW'(1);
                        if (tick_d) begin
                            prev_q <= Count;
                            if (state_q == PRIME) begin
                                state_q <= RUN;
                            end else begin
                                pos_q   <= Count;
                                vel_q   <= vel_d;
                                sat_q   <= sat_d;
                                avg_q   <= avg_d;
                                valid_q <= 1'b1;
                                hist_q[0] <= vel_d;
                                for (int i = 1; i < N; i++) hist_q[i] <= hist_q[i-1];
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign Velocity         = vel_q;
    assign Velocity_avg     = avg_q;
    assign Position_latched = pos_q;
    assign sample_valid     = valid_q;
    assign saturated        = sat_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_encoder_velocity.sv
// Self-checking bench for encoder_velocity: directed scenarios plus random windows,
// compared against an arithmetic model of windows, clamping, averaging and handshake.
module tb_encoder_velocity;

    localparam int W     = 8;
    localparam int VW    = 16;
    localparam int AVG_N = 4;

    logic                 clk = 1'b0;
    logic                 rst_drv = 1'b1;
    logic                 en_drv = 1'b0;
    logic                 ack_drv = 1'b0;
    logic signed [31:0]   cnt_drv = 32'sd100;
    logic signed [VW-1:0] vel;
    logic signed [VW-1:0] avg;
    logic signed [31:0]   pos;
    logic                 sv;
    logic                 sat;
    logic                 ovr;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit                 m_active = 1'b0;
    int                 m_n = 0;
    bit                 m_valid = 1'b0;
    bit                 m_unacked = 1'b0;
    bit                 m_ovr = 1'b0;
    bit                 m_sat = 1'b0;
    longint             m_vel = 0;
    longint             m_avg = 0;
    logic signed [31:0] m_pos = 32'sd0;
    logic signed [31:0] m_prev = 32'sd0;
    int                 hist[$] = '{0, 0, 0, 0};
    int                 ack_mode = 2;
    bit                 valid_prev_cycle = 1'b0;

    encoder_velocity #(.WINDOW(W), .VEL_W(VW), .AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst_drv), .enable(en_drv), .Count(cnt_drv),
        .Velocity(vel), .Velocity_avg(avg), .Position_latched(pos),
        .sample_valid(sv), .sample_ack(ack_drv), .saturated(sat), .overrun(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_n = 0; m_valid = 1'b0; m_unacked = 1'b0; m_ovr = 1'b0;
        m_sat = 1'b0; m_vel = 0; m_avg = 0; m_pos = '0; m_prev = '0;
        hist = '{0, 0, 0, 0};
    endtask

    task automatic model_edge();
        bit     pv;
        longint d;
        longint s;
        pv = m_valid;
        m_valid = 1'b0;
        if (rst_drv) begin
            model_reset();
        end else if (!m_active) begin
            if (en_drv) begin
                m_active = 1'b1; m_n = 0; hist = '{0, 0, 0, 0};
            end
        end else if (!en_drv) begin
            m_active = 1'b0; m_unacked = 1'b0; m_ovr = 1'b0; hist = '{0, 0, 0, 0};
        end else begin
            if (pv) begin
                if (m_unacked && !ack_drv) m_ovr = 1'b1;
                m_unacked = 1'b1;
            end else if (ack_drv) begin
                m_unacked = 1'b0;
            end
            m_n++;
            if (m_n % W == 0) begin
                if (m_n == W) begin
                    m_prev = cnt_drv;
                end else begin
                    d = longint'(cnt_drv) - longint'(m_prev);
                    if (d > 64'sd2147483647) d = d - 64'sd4294967296;
                    if (d < -64'sd2147483648) d = d + 64'sd4294967296;
                    m_sat = 1'b1;
                    if (d > 64'sd32767) m_vel = 32767;
                    else if (d < -64'sd32768) m_vel = -32768;
                    else begin m_vel = d; m_sat = 1'b0; end
                    m_pos = cnt_drv;
                    m_prev = cnt_drv;
                    hist.push_front(int'(m_vel));
                    void'(hist.pop_back());
                    s = 0;
                    foreach (hist[i]) s = s + hist[i];
                    m_avg = floor_div(s, AVG_N);
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("sample_valid", sv, m_valid);
        chk("Velocity", vel, m_vel);
        chk("Velocity_avg", avg, m_avg);
        chk("Position_latched", pos, m_pos);
        chk("saturated", sat, m_sat);
        chk("overrun", ovr, m_ovr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        case (ack_mode)
            0: ack_drv = m_valid;
            1: ack_drv = 1'b0;
            2: ack_drv = valid_prev_cycle;
            default: ack_drv = 1'($urandom_range(0, 1));
        endcase
        valid_prev_cycle = m_valid;
    endtask

    task automatic to_tick();
        int g = 0;
        do begin
            cycle();
            g++;
        end while (!(m_active && m_n > 0 && m_n % W == 0) && g < 4 * W);
        if (g >= 4 * W) begin
            n_assert++; n_fail++;
            $error("FAIL to_tick_timeout: observed %0d cycles expected under %0d", g, 4 * W);
        end
    endtask

    task automatic first_valid_latency(input string tag);
        int k;
        for (k = 0; k < 3 * W; k++) begin
            cycle();
            if (sv) break;
        end
        chk(tag, k, 2 * W);
    endtask

    initial begin
        int exp_avg[5] = '{0, 1, 2, 3, 3};
        // reset state
        #3;
        model_reset();
        check_all();
        repeat (2) cycle();
        rst_drv = 1'b0;
        repeat (2) cycle();

        // held count: prime window gives no pulse, first sample after two windows
        en_drv = 1'b1;
        first_valid_latency("first_valid_latency");
        chk("hold_velocity", vel, 0);
        chk("hold_position", pos, 100);
        repeat (2) to_tick();

        // constant +3 per window, average fills through zeros
        for (int i = 0; i < 5; i++) begin
            cnt_drv = cnt_drv + 32'sd3;
            to_tick();
            chk("ramp_velocity", vel, 3);
            chk("ramp_avg", avg, exp_avg[i]);
        end

        // wrap across the 32-bit boundary in both directions
        cnt_drv = 32'sh7FFF_FFFE;
        to_tick();
        cnt_drv = 32'sh8000_0001;
        to_tick();
        chk("wrap_up_velocity", vel, 3);
        chk("wrap_up_sat", sat, 0);
        cnt_drv = 32'sh7FFF_FFFE;
        to_tick();
        chk("wrap_down_velocity", vel, -3);

        // saturation both ways, then recovery
        cnt_drv = cnt_drv + 32'sd40000;
        to_tick();
        chk("sat_pos_velocity", vel, 32767);
        chk("sat_pos_flag", sat, 1);
        cnt_drv = cnt_drv - 32'sd40000;
        to_tick();
        chk("sat_neg_velocity", vel, -32768);
        chk("sat_neg_flag", sat, 1);
        cnt_drv = cnt_drv + 32'sd5;
        to_tick();
        chk("sat_clear_velocity", vel, 5);
        chk("sat_clear_flag", sat, 0);

        // overrun: two pulses without ack, cleared by dropping enable
        repeat (2) cycle();
        ack_mode = 1;
        repeat (2) to_tick();
        cycle();
        chk("overrun_set", ovr, 1);
        en_drv = 1'b0;
        cycle();
        chk("overrun_clear", ovr, 0);
        en_drv = 1'b1;
        ack_mode = 0;
        repeat (4) to_tick();
        cycle();
        chk("overrun_same_cycle_ack", ovr, 0);

        // randomized windows with random acks and occasional enable drops
        ack_mode = 3;
        for (int w = 0; w < 24; w++) begin
            int r;
            to_tick();
            r = int'($urandom_range(0, 9));
            if (r < 2) cnt_drv = $signed($urandom);
            else if (r < 4) cnt_drv = cnt_drv + 32'(int'($urandom_range(0, 100000)) - 50000);
            else cnt_drv = cnt_drv + 32'(int'($urandom_range(0, 400)) - 200);
            if (w % 8 == 7) begin
                en_drv = 1'b0;
                repeat (2) cycle();
                en_drv = 1'b1;
            end
        end

        // asynchronous reset mid-window, then a fresh prime
        ack_mode = 2;
        to_tick();
        repeat (3) cycle();
        #1 rst_drv = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        rst_drv = 1'b0;
        first_valid_latency("restart_latency");
        repeat (2) to_tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
